// File: rtl/ifetch_queue_pkg.sv
// Shared widths, FIFO depth, reset default and state encodings for the fetch queue.
package ifetch_queue_pkg;

  localparam int unsigned FULLW     = 32;
  localparam int unsigned IFQ_DEPTH = 2;
  localparam logic [FULLW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [FULLW-1:0] pc;
    logic [FULLW-1:0] instr;
  } ifq_entry_t;

  // Redirect targets are always word aligned; low bits are masked off.
  function automatic logic [FULLW-1:0] align_word(input logic [FULLW-1:0] addr);
    return addr & {{(FULLW-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction memory, redirect and decode handshake signals of the fetch queue.
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  logic [FULLW-1:0] imem_addr;
  logic [FULLW-1:0] imem_q;
  logic             br_take;
  logic [FULLW-1:0] br_target;
  logic             id_valid;
  logic             id_ready;
  logic [FULLW-1:0] id_instr;
  logic [FULLW-1:0] id_pc;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc,
    input  imem_q, br_take, br_target, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc,
    output imem_q, br_take, br_target, id_ready
  );

endinterface

// File: rtl/ifetch_queue_ifq2.sv
// Two-entry fetch FIFO with synchronous flush; the head entry is a register.
module ifq2
  import ifetch_queue_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       flush,
  input  logic       push,
  input  ifq_entry_t push_data,
  input  logic       pop,
  output logic       valid,
  output ifq_entry_t head,
  output logic [1:0] count
);

  ifq_entry_t tail;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: new data lands in head when it was the only entry.
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (count != 2'd0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: PC, one in-flight synchronous memory read, 2-deep decode queue.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [FULLW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic            clk,
  input logic            nreset,
  ifetch_queue_if.master bus
);

  logic [0:0]       state;
  logic [FULLW-1:0] pc;
  logic [FULLW-1:0] inflight_pc;
  logic             inflight;
  logic             hs;
  logic             issue;
  logic             enq;
  logic             fifo_valid;
  logic [1:0]       count;
  logic [2:0]       occupancy;
  ifq_entry_t       head;
  ifq_entry_t       push_data;

  assign hs        = fifo_valid & bus.id_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  // Slot reserved for the in-flight read; a same-cycle pop frees one more.
  assign issue     = (state == ST_RUN) && !bus.br_take &&
                     (occupancy < (3'd2 + {2'b00, hs}));
  assign enq       = inflight & ~bus.br_take;
  assign push_data = '{pc: inflight_pc, instr: bus.imem_q};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state <= ST_RUN;
      if (bus.br_take) begin
        pc       <= align_word(bus.br_target);
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= pc;
          pc          <= pc + 32'd4;
        end
      end
    end
  end

  ifq2 u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .flush     (bus.br_take),
    .push      (enq),
    .push_data (push_data),
    .pop       (hs),
    .valid     (fifo_valid),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_addr = pc;
  assign bus.id_valid  = fifo_valid;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc     = head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboarded bench for ifetch_queue: startup, stall, redirects, async reset, PC wrap.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  logic clk = 1'b0;
  logic nreset;
  logic nreset2;

  always #5 clk = ~clk;

  ifetch_queue_if bus ();
  ifetch_queue_if bus2 ();

  ifetch_queue dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk    (clk),
    .nreset (nreset2),
    .bus    (bus2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return 32'hA000_0000 + (addr >> 2);
  endfunction

  always @(posedge clk) begin
    bus.imem_q  <= instr_of(bus.imem_addr);
    bus2.imem_q <= instr_of(bus2.imem_addr);
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  ifq_entry_t  sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_fill(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 48; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      sb.push_back('{pc: a, instr: instr_of(a)});
    end
  endtask

  // Called at a negedge with inputs already driven for the coming edge.
  task automatic tick();
    ifq_entry_t e;
    if (bus.id_valid && bus.id_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", bus.id_pc, e.pc);
        check("sb_instr", bus.id_instr, e.instr);
      end
    end
    if (bus.br_take) sb_fill(bus.br_target & 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] hold_pc, hold_instr;
  logic [31:0] exp2 [4];

  initial begin
    exp2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    nreset = 1'b0;  nreset2 = 1'b0;
    bus.id_ready  = 1'b0; bus.br_take  = 1'b0; bus.br_target  = '0;
    bus2.id_ready = 1'b1; bus2.br_take = 1'b0; bus2.br_target = '0;
    @(negedge clk);
    @(negedge clk);

    check("rst_valid", bus.id_valid, 0);
    check("rst_pc", bus.id_pc, 0);
    check("rst_instr", bus.id_instr, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_count", dut.count, 0);
    check("rst_inflight", dut.inflight, 0);
    check("rst_state", dut.state, ST_IDLE);
    check("rst2_addr", bus2.imem_addr, 32'hFFFF_FFF8);

    // Startup: release in cycle 0.
    bus.id_ready = 1'b1;
    nreset = 1'b1;
    sb_fill(32'h0);
    check("c0_addr", bus.imem_addr, 0);
    tick();
    check("c1_valid", bus.id_valid, 0);
    check("c1_addr", bus.imem_addr, 0);
    check("c1_state", dut.state, ST_RUN);
    tick();
    check("c2_valid", bus.id_valid, 0);
    check("c2_addr", bus.imem_addr, 32'h4);
    tick();
    check("c3_valid", bus.id_valid, 1);
    check("c3_pc", bus.id_pc, 0);
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", bus.id_valid, 1);
      tick();
    end

    // Decode stall for 6 cycles.
    bus.id_ready = 1'b0;
    hold_pc = bus.id_pc;
    hold_instr = bus.id_instr;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_pc", bus.id_pc, hold_pc);
      check("stall_instr", bus.id_instr, hold_instr);
      check("stall_valid", bus.id_valid, 1);
    end
    check("stall_count", dut.count, 2);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("resume_valid", bus.id_valid, 1);
      tick();
    end

    // Redirect to an unaligned target.
    bus.br_target = 32'h0000_0043;
    bus.br_take = 1'b1;
    tick();
    bus.br_take = 1'b0;
    check("br1_n1_valid", bus.id_valid, 0);
    check("br1_n1_addr", bus.imem_addr, 32'h40);
    tick();
    check("br1_n2_valid", bus.id_valid, 0);
    tick();
    check("br1_n3_valid", bus.id_valid, 1);
    check("br1_n3_pc", bus.id_pc, 32'h40);
    for (int i = 0; i < 5; i++) tick();

    // Redirect with full FIFO and coincident handshake.
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("br2_full", dut.count, 2);
    bus.id_ready = 1'b1;
    bus.br_target = 32'h0000_0100;
    bus.br_take = 1'b1;
    tick();
    bus.br_take = 1'b0;
    check("br2_n1_valid", bus.id_valid, 0);
    tick();
    check("br2_n2_valid", bus.id_valid, 0);
    tick();
    check("br2_n3_valid", bus.id_valid, 1);
    check("br2_n3_pc", bus.id_pc, 32'h100);
    for (int i = 0; i < 4; i++) tick();

    // Asynchronous reset pulse between edges with the FIFO full.
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("ar_full", dut.count, 2);
    #2 nreset = 1'b0;
    #1;
    check("ar_valid", bus.id_valid, 0);
    check("ar_addr", bus.imem_addr, 0);
    check("ar_count", dut.count, 0);
    check("ar_inflight", dut.inflight, 0);
    #1 nreset = 1'b1;
    sb_fill(32'h0);
    bus.id_ready = 1'b1;
    @(negedge clk);
    check("ar_c1_valid", bus.id_valid, 0);
    check("ar_c1_addr", bus.imem_addr, 0);
    tick();
    check("ar_c2_valid", bus.id_valid, 0);
    tick();
    check("ar_c3_valid", bus.id_valid, 1);
    check("ar_c3_pc", bus.id_pc, 0);
    for (int i = 0; i < 4; i++) tick();

    // PC wrap from RESET_PC near the top of the address space.
    bus.id_ready = 1'b0;
    nreset2 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 4; i++) begin
      check("wrap_valid", bus2.id_valid, 1);
      check("wrap_pc", bus2.id_pc, exp2[i]);
      check("wrap_instr", bus2.id_instr, instr_of(exp2[i]));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
